// File: rtl/pulse_gate_ctrl.sv
// Gated pulse-count measurement controller: clears an external counter, enables it for a
// selectable gate length, then captures its value. Optional macro PULSE_GATE_OVF_EN adds cnt_ovf_in saturation.
module pulse_gate_ctrl #(
    parameter logic [31:0] GATE_0 = 32'd200_000_000,
    parameter logic [31:0] GATE_1 = 32'd100_000_000,
    parameter logic [31:0] GATE_2 = 32'd20_000_000,
    parameter logic [31:0] GATE_3 = 32'd2_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic       stop_in,
    input  logic       cont_in,
    input  logic [1:0] gate_sel_in,
    input  logic [7:0] cnt_val_in,
`ifdef PULSE_GATE_OVF_EN
    input  logic       cnt_ovf_in,
`endif
    output logic       cnt_clr_out,
    output logic       cnt_en_out,
    output logic [7:0] result_out,
    output logic       result_valid_out,
    input  logic       result_ready_in,
    output logic       busy_out,
    output logic       overrun_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_GATE    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_timer;
    logic [31:0] r_gate_len;
    logic        r_cont;
    logic        r_cnt_clr;
    logic        r_cnt_en;
    logic        r_busy;
    logic        r_valid;
    logic        r_overrun;
    logic [7:0]  r_result;
    logic [7:0]  w_capt_val;
    logic        w_capture;
    logic        w_idle_to_clear;

    // A zero-length gate still opens for one cycle so every measurement captures.
    function automatic logic [31:0] gate_len_f(input logic [1:0] sel);
        logic [31:0] n;
        case (sel)
            2'd0:    n = GATE_0;
            2'd1:    n = GATE_1;
            2'd2:    n = GATE_2;
            2'd3:    n = GATE_3;
            default: n = GATE_0;
        endcase
        if (n == 32'd0) begin
            gate_len_f = 32'd1;
        end else begin
            gate_len_f = n;
        end
    endfunction

    // Next-state decode; stop_in always has priority over start_in.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    w_next = ST_CLEAR;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (stop_in) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_GATE;
                end
            end
            ST_GATE: begin
                if (stop_in) begin
                    w_next = ST_IDLE;
                end else if (r_timer >= (r_gate_len - 32'd1)) begin
                    w_next = ST_CAPTURE;
                end else begin
                    w_next = ST_GATE;
                end
            end
            ST_CAPTURE: begin
                if (r_cont && !stop_in) begin
                    w_next = ST_CLEAR;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_capture       = (r_state == ST_CAPTURE);
    assign w_idle_to_clear = (r_state == ST_IDLE) && (w_next == ST_CLEAR);

`ifdef PULSE_GATE_OVF_EN
    logic r_ovf_seen;

    // Remember any counter overflow seen during the current gate.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ovf_seen <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_ovf_seen <= 1'b0;
        end else if ((r_state == ST_GATE) && cnt_ovf_in) begin
            r_ovf_seen <= 1'b1;
        end else begin
            r_ovf_seen <= r_ovf_seen;
        end
    end

    assign w_capt_val = r_ovf_seen ? 8'hFF : cnt_val_in;
`else
    assign w_capt_val = cnt_val_in;
`endif

    // State, gate timer and registered control outputs derived from the next state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_timer    <= 32'd0;
            r_gate_len <= 32'd1;
            r_cont     <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_cnt_en   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt_clr <= (w_next == ST_CLEAR);
            r_cnt_en  <= (w_next == ST_GATE);
            r_busy    <= (w_next != ST_IDLE);
            if (r_state == ST_GATE) begin
                r_timer <= r_timer + 32'd1;
            end else begin
                r_timer <= 32'd0;
            end
            if (r_state == ST_CLEAR) begin
                r_gate_len <= gate_len_f(gate_sel_in);
            end else begin
                r_gate_len <= r_gate_len;
            end
            if (stop_in) begin
                r_cont <= 1'b0;
            end else if (w_idle_to_clear) begin
                r_cont <= cont_in;
            end else begin
                r_cont <= r_cont;
            end
        end
    end

    // Result register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_result  <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            r_result <= w_capt_val;
            r_valid  <= 1'b1;
            if (r_valid && !result_ready_in) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end else begin
            r_result <= r_result;
            if (r_valid && result_ready_in) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
            if (w_idle_to_clear) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign cnt_clr_out      = r_cnt_clr;
    assign cnt_en_out       = r_cnt_en;
    assign busy_out         = r_busy;
    assign result_out       = r_result;
    assign result_valid_out = r_valid;
    assign overrun_out      = r_overrun;

endmodule

// File: doc/pulse_gate_ctrl.md
PULSE_GATE_CTRL -- requirements
Module: pulse_gate_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 GATE_0, 32'd200_000_000, gate length in clk_in cycles for gate_sel_in=0.
REQ-002 GATE_1, 32'd100_000_000, gate length for gate_sel_in=1.
REQ-003 GATE_2, 32'd20_000_000, gate length for gate_sel_in=2.
REQ-004 GATE_3, 32'd2_000_000, gate length for gate_sel_in=3.
Ports (name, direction, width, meaning):
REQ-005 clk_in, input, 1, single clock; all logic on posedge.
REQ-006 rst_n_in, input, 1, reset, asynchronous, active-low.
REQ-007 start_in, input, 1, level-sampled request to begin measurement.
REQ-008 stop_in, input, 1, abort current measurement, clear continuous run.
REQ-009 cont_in, input, 1, continuous mode (re-arm after each capture).
REQ-010 gate_sel_in, input, 2, gate length select.
REQ-011 cnt_val_in, input, 8, count value from external pulse counter.
REQ-012 cnt_clr_out, output, 1, synchronous clear to external counter.
REQ-013 cnt_en_out, output, 1, count enable to external counter.
REQ-014 result_out, output, 8, captured count.
REQ-015 result_valid_out / result_ready_in, output / input, 1 each, result handshake.
REQ-016 busy_out, output, 1, high whenever state is not IDLE.
REQ-017 overrun_out, output, 1, sticky: an unconsumed result was overwritten.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, GATE, CAPTURE.
REQ-019 IDLE->CLEAR when start_in=1 and stop_in=0; stop_in wins if both are high.
REQ-020 CLEAR lasts 1 cycle: cnt_clr_out=1, cnt_en_out=0; gate_sel_in sampled and held; timer loaded 0.
REQ-021 GATE: cnt_en_out=1 for exactly N cycles (N = selected GATE_x); N=0 treated as 1; timer 32-bit, no wrap.
REQ-022 CAPTURE lasts 1 cycle: cnt_en_out=0; result_out<=cnt_val_in; result_valid_out=1 from next cycle.
REQ-023 After CAPTURE: CLEAR if the latched continuous flag is set, else IDLE.
REQ-024 Latency: start_in sampled at cycle t -> cnt_clr_out at t+1, cnt_en_out at t+2..t+N+1, capture at t+N+2, result_valid_out at t+N+3.
REQ-025 Continuous flag latched from cont_in on IDLE->CLEAR; cleared by stop_in.
REQ-026 stop_in in CLEAR/GATE -> IDLE next cycle, no capture, result unchanged; in CAPTURE the capture completes, then IDLE.
REQ-027 start_in outside IDLE SHALL be ignored.
REQ-028 result_valid_out clears the cycle after valid&ready; result_out is stable while valid=1 and ready=0.
REQ-029 Capture while valid=1 and ready=0: result overwritten, valid stays 1, overrun_out<=1.
REQ-030 Capture in the same cycle as valid&ready: new result taken, valid stays 1, no overrun.
REQ-031 overrun_out clears only on IDLE->CLEAR transition.

Reset
REQ-032 Reset asserted: state=IDLE, all outputs 0, result_out=8'h00, timer 0, continuous flag 0.
REQ-033 Reset mid-GATE SHALL drop cnt_en_out immediately (asynchronous); no capture.

Configuration
REQ-034 Macro PULSE_GATE_OVF_EN: when defined, input cnt_ovf_in (1 bit) SHALL exist; if high in any GATE cycle, result_out=8'hFF at capture (saturation).
REQ-035 Without PULSE_GATE_OVF_EN: cnt_ovf_in absent; result_out = raw cnt_val_in (wraps modulo 256).

Verification
REQ-036 GATE_3=10, gate_sel=3, start pulse, counter counts every enabled cycle -> cnt_en_out high exactly 10 cycles, result_out=10, valid at t+13.
REQ-037 cont_in=1, ready held 0, two gates -> second capture overwrites, overrun_out=1, valid stays 1; next start clears overrun.
REQ-038 stop_in at 5th GATE cycle -> IDLE next cycle, cnt_en_out=0, result_valid_out stays 0.
REQ-039 start_in and stop_in both high in IDLE -> remains IDLE, busy_out=0.
REQ-040 rst_n_in low mid-GATE -> all outputs 0 asynchronously; after release start works normally.
REQ-041 PULSE_GATE_OVF_EN defined, cnt_ovf_in pulsed during GATE -> result_out=8'hFF; undefined, 300 pulses -> result_out=8'd44.
